// File: rtl/test_mailbox_pkg.sv
// Shared definitions for the test mailbox.
//   state_e     : global run state (IDLE, RUN, DONE, TIMEOUT)
//   FLAG_OFS    : byte offset of a channel's FLAG register within its slot
//   RESULT_OFS  : byte offset of a channel's RESULT register within its slot
//   CH_STRIDE   : byte distance between consecutive channel slots
//   STATUS_ADDR : byte address of the read-only STATUS register
//   reg_addr()  : byte address of a channel register
package test_mailbox_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE,
    ST_TIMEOUT
  } state_e;

  localparam int FLAG_OFS    = 0;
  localparam int RESULT_OFS  = 4;
  localparam int CH_STRIDE   = 8;
  localparam int STATUS_ADDR = 'h80;

  function automatic int reg_addr(int ch, int ofs);
    return ch * CH_STRIDE + ofs;
  endfunction

endpackage

// File: rtl/test_mailbox_ch.sv
// One mailbox channel: a sticky completion flag and a result register.
// The result is writable only while the flag is clear, so setting the flag
// freezes whatever result was reported before it.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   flag_we      : write strobe for this channel's FLAG register
//   result_we    : write strobe for this channel's RESULT register
//   wdata        : write data
//   flag         : sticky completion flag
//   result       : latched result
module test_mailbox_ch #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flag_we,
  input  logic              result_we,
  input  logic [DATA_W-1:0] wdata,
  output logic              flag,
  output logic [DATA_W-1:0] result
);

  // NOTE: non-blocking assignments for every register so all state updates
  // in this clock edge see the pre-edge values (the freeze test below reads
  // the old flag, not the one being set this cycle).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: the result register is reset explicitly because its value is
      // visible on result_o straight out of reset.
      flag   <= 1'b0;
      result <= '0;
    end else begin
      // A zero write is a no-op; nothing but reset clears the flag.
      if (flag_we && (wdata != '0)) flag <= 1'b1;
      if (result_we && !flag) result <= wdata;
    end
  end

endmodule

// File: rtl/test_mailbox.sv
// Test mailbox: collects per-hart completion flags and results during a
// test run and reports done/timeout plus a run-cycle count.
// Optional feature: define TEST_MAILBOX_EXPECT_EN to add expect_i/pass_o,
// comparing all results against an expected vector once the run is done.
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset
//   fetch_enable_i : core run enable; starts the run and gates cycle counting
//   we_i, re_i     : write / read strobes
//   addr_i         : byte address (bits [1:0] ignored)
//   wdata_i        : write data
//   rdata_o        : read data, one cycle after re_i, held otherwise
//   flag_o         : per-channel sticky flags
//   result_o       : per-channel results, channel 0 in the LSBs
//   done_o         : all flags set before timeout
//   timeout_o      : run expired before all flags were set
//   cycles_o       : saturating run-cycle counter
//   expect_i       : (TEST_MAILBOX_EXPECT_EN) expected results
//   pass_o         : (TEST_MAILBOX_EXPECT_EN) done and all results match
module test_mailbox
  import test_mailbox_pkg::*;
#(
  parameter int          NUM_CH      = 2,
  parameter int          DATA_W      = 32,
  parameter int          ADDR_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     fetch_enable_i,
  input  logic                     we_i,
  input  logic                     re_i,
  input  logic [ADDR_W-1:0]        addr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  output logic [DATA_W-1:0]        rdata_o,
  output logic [NUM_CH-1:0]        flag_o,
  output logic [NUM_CH*DATA_W-1:0] result_o,
  output logic                     done_o,
  output logic                     timeout_o,
  output logic [31:0]              cycles_o
`ifdef TEST_MAILBOX_EXPECT_EN
  ,
  input  logic [NUM_CH*DATA_W-1:0] expect_i,
  output logic                     pass_o
`endif
);

  state_e              state, state_next;
  logic [ADDR_W-1:0]   addr_al;
  logic                addr_lsb_unused;
  logic                wr_ok;
  logic                run;
  logic                all_flags;
  logic                cnt_en;
  logic [NUM_CH-1:0]   flag_we, result_we, flag_set;
  logic [31:0]         status;
  logic [DATA_W-1:0]   rd_mux;

  assign addr_al         = {addr_i[ADDR_W-1:2], 2'b00};
  assign addr_lsb_unused = ^addr_i[1:0];

  // Writes are taken while idle (preload) and while running; DONE and
  // TIMEOUT freeze the mailbox until reset.
  assign wr_ok = we_i && ((state == ST_IDLE) || (state == ST_RUN));

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    localparam logic [ADDR_W-1:0] FLAG_ADDR   = ADDR_W'(reg_addr(ch, FLAG_OFS));
    localparam logic [ADDR_W-1:0] RESULT_ADDR = ADDR_W'(reg_addr(ch, RESULT_OFS));

    assign flag_we[ch]   = wr_ok && (addr_al == FLAG_ADDR);
    assign result_we[ch] = wr_ok && (addr_al == RESULT_ADDR);
    assign flag_set[ch]  = flag_we[ch] && (wdata_i != '0);

    test_mailbox_ch #(
      .DATA_W (DATA_W)
    ) u_ch (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .flag_we   (flag_we[ch]),
      .result_we (result_we[ch]),
      .wdata     (wdata_i),
      .flag      (flag_o[ch]),
      .result    (result_o[ch*DATA_W +: DATA_W])
    );
  end

  // Include flags being set this cycle so DONE appears the cycle right after
  // the last flag write, and so a last write on the timeout cycle wins.
  assign all_flags = &(flag_o | flag_set);

  // Counting stops once the limit is reached so cycles_o reads exactly
  // TIMEOUT_CYC in the timeout state; the all-ones test keeps the counter
  // saturating even for a limit at the top of the range.
  assign cnt_en = (state == ST_RUN) && fetch_enable_i &&
                  (cycles_o < TIMEOUT_CYC) && (cycles_o != '1);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    state_next = state;
    run        = 1'b0;
    done_o     = 1'b0;
    timeout_o  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (fetch_enable_i) state_next = ST_RUN;
      end
      ST_RUN: begin
        run = 1'b1;
        if (all_flags) state_next = ST_DONE;
        else if (cycles_o >= TIMEOUT_CYC) state_next = ST_TIMEOUT;
      end
      ST_DONE:    done_o    = 1'b1;
      ST_TIMEOUT: timeout_o = 1'b1;
      default: ;
    endcase
  end

  assign status = {cycles_o[15:0], 13'b0, timeout_o, done_o, run};

  // Read mux over the pre-write register values.
  always_comb begin
    rd_mux = '0;
    if ((ADDR_W >= 8) && (addr_al == ADDR_W'(STATUS_ADDR))) rd_mux = DATA_W'(status);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (addr_al == ADDR_W'(reg_addr(ch, FLAG_OFS)))   rd_mux = DATA_W'(flag_o[ch]);
      if (addr_al == ADDR_W'(reg_addr(ch, RESULT_OFS))) rd_mux = result_o[ch*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      cycles_o <= '0;
      rdata_o  <= '0;
    end else begin
      state <= state_next;
      if (cnt_en) cycles_o <= cycles_o + 32'd1;
      if (re_i)   rdata_o  <= rd_mux;
    end
  end

`ifdef TEST_MAILBOX_EXPECT_EN
  // Results are frozen once DONE is reached, so one registered compare
  // after done_o is stable for the rest of the run.
  always_ff @(posedge clk_i) begin
    if (rst_i) pass_o <= 1'b0;
    else       pass_o <= done_o && (result_o == expect_i);
  end
`endif

endmodule
